millis_timer: RTL and testbench
===============================

MILLIS_TIMER -- requirements
Module: millis_timer

Interface
REQ-001 The block SHALL have parameter TIMER_WIDTH, default 32, setting the width of the millisecond count output in bits.
REQ-002 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, giving the frequency of clk in Hz.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-005 The block SHALL have port dout, output, TIMER_WIDTH bits, the count of milliseconds elapsed since reset release.

Function
REQ-006 The block SHALL define DIV = CLK_FREQ_HZ / 1000 (integer division) as clock cycles per millisecond.
REQ-007 The block SHALL contain a prescaler counter of width max(1, clog2(DIV)) bits, sized to hold 0..DIV-1.
REQ-008 On each rising clk edge out of reset, with prescaler < DIV-1, the block SHALL increment the prescaler by 1 and hold dout.
REQ-009 On the rising clk edge where the prescaler equals DIV-1, the block SHALL load 0 into the prescaler and load dout+1 into dout.
REQ-010 The block SHALL increment dout exactly once per DIV clock cycles, with no skipped or double increments.
REQ-011 After reset release, the block SHALL raise the first increment (dout 0 -> 1) on the DIV-th rising edge, and the N-th increment on edge N*DIV.
REQ-012 When dout equals 2^TIMER_WIDTH-1 and an increment occurs, dout SHALL wrap to 0 and keep counting, with no flag or saturation.
REQ-013 dout SHALL be driven directly from a register, with no combinational path from any input.
REQ-014 With DIV = 1, the block SHALL increment dout on every rising clk edge.
REQ-015 A CLK_FREQ_HZ below 1000 (DIV = 0) SHALL be rejected at elaboration with an error.
REQ-016 The block SHALL include no enable, load or clear input; counting is free-running.

Reset
REQ-017 While reset = 0, the prescaler and dout SHALL be held at 0, regardless of clk.
REQ-018 Assertion of reset SHALL clear the prescaler and dout immediately, without waiting for a clk edge, including mid-millisecond.
REQ-019 After reset deasserts, counting SHALL restart from prescaler 0, so the first full DIV-cycle period is measured from the first rising edge after release.
REQ-020 Deasserting reset coincident with a clk edge SHALL NOT produce a partial count; the first increment still needs DIV edges after that edge.

Verification
REQ-021 Default parameters, 50 MHz clk, reset held low 2 cycles then released -> dout = 0 for edges 1..49999, and dout = 1 after edge 50000.
REQ-022 Default parameters, run until dout = 5 -> exactly 250000 edges after release, with each increment exactly 50000 edges after the previous one.
REQ-023 Concurrent property check: on any edge where the reference divider equals DIV-1 -> next sample of dout equals previous dout + 1; at all other edges -> dout unchanged.
REQ-024 CLK_FREQ_HZ = 4000 (DIV = 4), TIMER_WIDTH = 3, run 32 edges -> dout steps 0..7 then wraps to 0 at edge 32.
REQ-025 CLK_FREQ_HZ = 4000, reset asserted asynchronously between edges when dout = 2 and prescaler = 2 -> dout and prescaler read 0 before the next edge; after release the next increment is at edge 4.
REQ-026 CLK_FREQ_HZ = 1000 (DIV = 1) -> dout increments on every edge: 1, 2, 3, and so on.

Source files
------------

// File: rtl/millis_timer.sv
// ---------------------------------------------------------------------------
// millis_timer
//   Free-running millisecond counter. A prescaler divides clk down to a
//   1 kHz tick. Each tick advances the millisecond count by one. The count
//   wraps silently at 2^TIMER_WIDTH.
//
// Parameters
//   TIMER_WIDTH : width of the millisecond count in bits
//   CLK_FREQ_HZ : frequency of clk in Hz; must be at least 1000
//
// Ports
//   clk   : single clock; all state updates on its rising edge
//   reset : asynchronous active-low reset (0 = in reset)
//   dout  : milliseconds elapsed since reset release, driven from a register
// ---------------------------------------------------------------------------
module millis_timer #(
  parameter int TIMER_WIDTH = 32,
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [TIMER_WIDTH-1:0] dout
);

  // Clock cycles per millisecond
  localparam int DIV   = CLK_FREQ_HZ / 1000;
  // A one-cycle divider still needs a 1-bit prescaler so the compare is legal
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'((DIV > 0) ? DIV - 1 : 0);

  // A clock slower than 1 kHz cannot produce a millisecond tick at all
  generate
    if (DIV < 1) begin : g_bad_freq
      $error("millis_timer: CLK_FREQ_HZ must be >= 1000");
    end
  endgenerate

  logic [PRE_W-1:0]       r_prescaler;
  logic [TIMER_WIDTH-1:0] r_dout;
  logic                   w_tick;

  // The tick fires on the last cycle of each millisecond window
  assign w_tick = (r_prescaler == PRE_MAX);

  // The prescaler restarts from 0 after every tick and after reset, so the
  // first tick always falls exactly DIV edges after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescaler <= '0;
      r_dout      <= '0;
    end else if (w_tick) begin
      r_prescaler <= '0;
      r_dout      <= r_dout + TIMER_WIDTH'(1);
    end else begin
      r_prescaler <= r_prescaler + PRE_W'(1);
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_millis_timer.sv
// ---------------------------------------------------------------------------
// tb_millis_timer
//   Self-checking bench for millis_timer. Three instances share one clock:
//     small : CLK_FREQ_HZ=4000 (DIV=4), TIMER_WIDTH=3
//     unit  : CLK_FREQ_HZ=1000 (DIV=1), TIMER_WIDTH=4
//     mid   : CLK_FREQ_HZ=5000 (DIV=5), TIMER_WIDTH=8
//   Expected counts come from a reference divider model and pass through a
//   scoreboard queue before being compared against the sampled outputs.
// ---------------------------------------------------------------------------
module tb_millis_timer;

  logic       clk;
  logic       rstSmall;
  logic       rstUnit;
  logic       rstMid;
  logic [2:0] doutSmall;
  logic [3:0] doutUnit;
  logic [7:0] doutMid;

  int checks;
  int errors;
  int expQ[$];

  millis_timer #(.TIMER_WIDTH(3), .CLK_FREQ_HZ(4000)) u_small (
    .clk   (clk),
    .reset (rstSmall),
    .dout  (doutSmall)
  );

  millis_timer #(.TIMER_WIDTH(4), .CLK_FREQ_HZ(1000)) u_unit (
    .clk   (clk),
    .reset (rstUnit),
    .dout  (doutUnit)
  );

  millis_timer #(.TIMER_WIDTH(8), .CLK_FREQ_HZ(5000)) u_mid (
    .clk   (clk),
    .reset (rstMid),
    .dout  (doutMid)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divider: advances the model prescaler and count by one edge
  function automatic void stepModel(input int div, input int width,
                                    inout int pre, inout int cnt);
    if (pre == div - 1) begin
      pre = 0;
      cnt = (cnt + 1) & ((1 << width) - 1);
    end else begin
      pre = pre + 1;
    end
  endfunction

  // All instances held in reset; outputs and prescalers must read zero
  // across clock edges, then every instance is released on a falling edge
  task automatic test_reset();
    rstSmall = 1'b0;
    rstUnit  = 1'b0;
    rstMid   = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (doutSmall !== 3'd0) begin
        errors++;
        $display("[TB] FAIL reset_small_dout got %0d expected 0", doutSmall);
      end
      checks++;
      if (doutUnit !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_unit_dout got %0d expected 0", doutUnit);
      end
      checks++;
      if (doutMid !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_mid_dout got %0d expected 0", doutMid);
      end
      checks++;
      if (u_small.r_prescaler !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_small_pre got %0d expected 0", u_small.r_prescaler);
      end
    end
    @(negedge clk);
    rstSmall = 1'b1;
    rstUnit  = 1'b1;
    rstMid   = 1'b1;
  endtask

  // DIV=4, width 3: 32 edges step 0..7 and wrap back to 0 at edge 32
  task automatic test_wrap_small();
    int pre = 0;
    int cnt = 0;
    int got;
    for (int e = 1; e <= 32; e++) begin
      stepModel(4, 3, pre, cnt);
      expQ.push_back(cnt);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checks++;
      if (doutSmall !== 3'(got)) begin
        errors++;
        $display("[TB] FAIL wrap_small edge %0d got %0d expected %0d", e, doutSmall, got);
      end
    end
  endtask

  // DIV=1: the count advances on every edge and wraps at 16
  task automatic test_unit_div();
    int pre = 0;
    int cnt = 0;
    int got;
    for (int e = 1; e <= 20; e++) begin
      stepModel(1, 4, pre, cnt);
      expQ.push_back(cnt);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checks++;
      if (doutUnit !== 4'(got)) begin
        errors++;
        $display("[TB] FAIL unit_div edge %0d got %0d expected %0d", e, doutUnit, got);
      end
    end
  endtask

  // Reset the small instance, run to dout=2 / prescaler=2, then assert reset
  // between edges: both must clear before the next edge, and after release
  // the first increment must again land on edge 4
  task automatic test_async_reset();
    int pre;
    int cnt;
    int got;
    @(negedge clk);
    rstSmall = 1'b0;
    @(negedge clk);
    rstSmall = 1'b1;
    pre = 0;
    cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      stepModel(4, 3, pre, cnt);
      expQ.push_back(cnt);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checks++;
      if (doutSmall !== 3'(got)) begin
        errors++;
        $display("[TB] FAIL async_pre_run edge %0d got %0d expected %0d", e, doutSmall, got);
      end
    end
    checks++;
    if (u_small.r_prescaler !== 2'(pre)) begin
      errors++;
      $display("[TB] FAIL async_pre_value got %0d expected %0d", u_small.r_prescaler, pre);
    end
    #2;
    rstSmall = 1'b0;
    #1;
    checks++;
    if (doutSmall !== 3'd0) begin
      errors++;
      $display("[TB] FAIL async_clear_dout got %0d expected 0", doutSmall);
    end
    checks++;
    if (u_small.r_prescaler !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_clear_pre got %0d expected 0", u_small.r_prescaler);
    end
    @(negedge clk);
    rstSmall = 1'b1;
    pre = 0;
    cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      stepModel(4, 3, pre, cnt);
      expQ.push_back(cnt);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checks++;
      if (doutSmall !== 3'(got)) begin
        errors++;
        $display("[TB] FAIL async_restart edge %0d got %0d expected %0d", e, doutSmall, got);
      end
    end
  endtask

  // DIV=5, width 8: a long run through the 8-bit wrap, checking every edge
  // so that any skipped or doubled increment is caught
  task automatic test_back_to_back();
    int pre = 0;
    int cnt = 0;
    int got;
    @(negedge clk);
    rstMid = 1'b0;
    @(negedge clk);
    rstMid = 1'b1;
    for (int e = 1; e <= 1300; e++) begin
      stepModel(5, 8, pre, cnt);
      expQ.push_back(cnt);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checks++;
      if (doutMid !== 8'(got)) begin
        errors++;
        $display("[TB] FAIL mid_run edge %0d got %0d expected %0d", e, doutMid, got);
      end
    end
  endtask

  // Test sequence; every scoreboard entry must have been consumed at the end
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    fork
      test_wrap_small();
      test_unit_div();
    join
    test_async_reset();
    test_back_to_back();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
